// File: rtl/alu_result_fifo.sv
// Buffers ALU results (select, result, carry, zero, overflow) in a DEPTH-entry FIFO.
// Define ALU_RESULT_FIFO_STICKY_EN to compile in the sticky carry/overflow flags.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_select,
    input  logic [3:0]                 in_s,
    input  logic                       in_c,
    input  logic                       in_zero,
    input  logic                       in_overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_select,
    output logic [3:0]                 out_s,
    output logic                       out_c,
    output logic                       out_zero,
    output logic                       out_overflow,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       sticky_clr,
    output logic                       sticky_c,
    output logic                       sticky_ov
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 10;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    // Handshake status comes only from the registered occupancy.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != CNT_W'(0));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage needs no reset; only the head slot is ever visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_select, in_s, in_c, in_zero, in_overflow};
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = out_valid ? mem[rd_ptr] : '0;
    assign {out_select, out_s, out_c, out_zero, out_overflow} = head;

`ifdef ALU_RESULT_FIFO_STICKY_EN
    // A flag arriving with a push wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_c  <= 1'b0;
            sticky_ov <= 1'b0;
        end else begin
            sticky_c  <= (sticky_c  && !sticky_clr) || (push && in_c);
            sticky_ov <= (sticky_ov && !sticky_clr) || (push && in_overflow);
        end
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_c          = 1'b0;
    assign sticky_ov         = 1'b0;
`endif

endmodule
